// File: rtl/conv_cfg_pkg.sv
// Shared constants for the converter configuration sequencer:
// entry layout, FSM encoding and the default register-write table.
package conv_cfg_pkg;

  localparam int ENTRY_W    = 34;
  localparam int E_TGT      = 33;
  localparam int E_VFY      = 32;
  localparam int E_ADDR_LSB = 16;
  localparam int E_DATA_LSB = 0;

  localparam logic TGT_ADC = 1'b0;
  localparam logic TGT_DAC = 1'b1;

  localparam logic [15:0] RD_FLAG = 16'h8000;

  localparam logic [2:0] S_DELAY = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  // ADC reg 1: software reset
  localparam logic [ENTRY_W-1:0] ENT_ADC_RST =
    {TGT_ADC, 1'b0, 16'h0001, 16'h0080};
  // ADC reg 3: 2-lane output mode
  localparam logic [ENTRY_W-1:0] ENT_ADC_LANE =
    {TGT_ADC, 1'b0, 16'h0003, 16'h0001};
  // DAC reg 0, read back
  localparam logic [ENTRY_W-1:0] ENT_DAC_R0 =
    {TGT_DAC, 1'b1, 16'h0000, 16'h0020};
  // DAC reg 2, read back
  localparam logic [ENTRY_W-1:0] ENT_DAC_R2 =
    {TGT_DAC, 1'b1, 16'h0002, 16'h0000};

  // Unused slots repeat the idempotent lane-mode write, never the reset.
  function automatic logic [ENTRY_W-1:0] cfg_entry(
    input logic [7:0] i
  );
    logic [ENTRY_W-1:0] e;
    case (i)
      8'd0:    e = ENT_ADC_RST;
      8'd1:    e = ENT_ADC_LANE;
      8'd2:    e = ENT_DAC_R0;
      8'd3:    e = ENT_DAC_R2;
      default: e = ENT_ADC_LANE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/conv_cfg_rom.sv
// Combinational lookup of table index to 34-bit write entry.
// Indices past the table end read as all-zero.
module conv_cfg_rom
  import conv_cfg_pkg::*;
#(
  parameter int N_ENTRIES = 8
) (
  input  logic [7:0]         idx_i,
  output logic [ENTRY_W-1:0] entry_o
);

  localparam logic [8:0] N_L = 9'(N_ENTRIES);

  // Table read, guarded against out-of-range indices
  always_comb begin
    entry_o = '0;
    if ({1'b0, idx_i} < N_L) begin
      entry_o = cfg_entry(idx_i);
    end
  end

endmodule

// File: rtl/converter_config_sequencer.sv
// Plays a fixed register-write table into the LTC2195 / AD9783
// command ports, verifying selected DAC writes with bounded retry.
module converter_config_sequencer
  import conv_cfg_pkg::*;
#(
  parameter int N_ENTRIES   = 8,
  parameter int GAP_CYCLES  = 512,
  parameter int START_DELAY = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic        adc_cmd_trig_out,
  output logic [15:0] adc_cmd_addr_out,
  output logic [15:0] adc_cmd_data_out,
  output logic        dac_cmd_trig_out,
  output logic [15:0] dac_cmd_addr_out,
  output logic [15:0] dac_cmd_data_out,
  input  logic [15:0] dac_rdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out,
  output logic [7:0]  err_index_out
);

  localparam int CNT_MAX =
    (GAP_CYCLES > START_DELAY) ? GAP_CYCLES : START_DELAY;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] DLY_LIM   = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_CYCLES - 1);
  // One cycle shorter when S_NEXT follows, so triggers stay GAP+1 apart
  localparam logic [CW-1:0] GAP_LIM_S = CW'(GAP_CYCLES - 2);
  localparam logic [7:0]    LAST_IDX  = 8'(N_ENTRIES - 1);
  localparam logic [RW-1:0] RTY_LAST  = RW'(MAX_RETRY - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    idx_q, idx_d;
  logic          adc_trig_q, adc_trig_d;
  logic [15:0]   adc_addr_q, adc_addr_d;
  logic [15:0]   adc_data_q, adc_data_d;
  logic          dac_trig_q, dac_trig_d;
  logic [15:0]   dac_addr_q, dac_addr_d;
  logic [15:0]   dac_data_q, dac_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    err_idx_q, err_idx_d;

  logic [ENTRY_W-1:0] entry;
  logic               is_dac;
  logic               vfy;
  logic [15:0]        ent_addr;
  logic [15:0]        ent_data;
  logic [CW-1:0]      wait_lim;
  logic               rd_match;
  logic               rdata_unused;

  conv_cfg_rom #(
    .N_ENTRIES(N_ENTRIES)
  ) u_rom (
    .idx_i  (idx_q),
    .entry_o(entry)
  );

  assign is_dac   = entry[E_TGT];
  assign vfy      = is_dac & entry[E_VFY];
  assign ent_addr = entry[E_ADDR_LSB +: 16];
  assign ent_data = entry[E_DATA_LSB +: 16];
  assign wait_lim = vfy ? GAP_LIM : GAP_LIM_S;
  assign rd_match = dac_rdata_in[7:0] == ent_data[7:0];
  assign rdata_unused = ^dac_rdata_in[15:8];

  // Sequencer next-state, counters and registered bus outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    adc_trig_d = 1'b0;
    adc_addr_d = adc_addr_q;
    adc_data_d = adc_data_q;
    dac_trig_d = 1'b0;
    dac_addr_d = dac_addr_q;
    dac_data_d = dac_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      S_DELAY: begin
        if (cnt_q == DLY_LIM) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
        if (is_dac) begin
          dac_trig_d = 1'b1;
          dac_addr_d = ent_addr;
          dac_data_d = ent_data;
        end else begin
          adc_trig_d = 1'b1;
          adc_addr_d = ent_addr;
          adc_data_d = ent_data;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_lim) begin
          cnt_d   = '0;
          state_d = vfy ? S_READ : S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        dac_trig_d = 1'b1;
        dac_addr_d = ent_addr | RD_FLAG;
        dac_data_d = '0;
        cnt_d      = '0;
        state_d    = S_RWAIT;
      end
      S_RWAIT: begin
        if (cnt_q == GAP_LIM) begin
          cnt_d = '0;
          if (rd_match) begin
            state_d = S_NEXT;
          end else if (retry_q < RTY_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            err_idx_d = idx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE, S_ERROR: begin
        if (start_in) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          retry_d   = '0;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      default: state_d = S_DELAY;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_DELAY;
      cnt_q      <= '0;
      retry_q    <= '0;
      idx_q      <= '0;
      adc_trig_q <= 1'b0;
      adc_addr_q <= '0;
      adc_data_q <= '0;
      dac_trig_q <= 1'b0;
      dac_addr_q <= '0;
      dac_data_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      adc_trig_q <= adc_trig_d;
      adc_addr_q <= adc_addr_d;
      adc_data_q <= adc_data_d;
      dac_trig_q <= dac_trig_d;
      dac_addr_q <= dac_addr_d;
      dac_data_q <= dac_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign adc_cmd_trig_out = adc_trig_q;
  assign adc_cmd_addr_out = adc_addr_q;
  assign adc_cmd_data_out = adc_data_q;
  assign dac_cmd_trig_out = dac_trig_q;
  assign dac_cmd_addr_out = dac_addr_q;
  assign dac_cmd_data_out = dac_data_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign error_out        = err_q;
  assign err_index_out    = err_idx_q;

endmodule

// File: tb/tb_converter_config_sequencer.sv
// Directed bench for converter_config_sequencer with a small
// AD9783 readback model and a per-cycle command bus monitor.
module tb_converter_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        adc_cmd_trig_out;
  logic [15:0] adc_cmd_addr_out;
  logic [15:0] adc_cmd_data_out;
  logic        dac_cmd_trig_out;
  logic [15:0] dac_cmd_addr_out;
  logic [15:0] dac_cmd_data_out;
  logic [15:0] dac_rdata_in = 16'h0;
  logic        busy_out;
  logic        done_out;
  logic        error_out;
  logic [7:0]  err_index_out;

  converter_config_sequencer #(
    .N_ENTRIES  (4),
    .GAP_CYCLES (8),
    .START_DELAY(16),
    .MAX_RETRY  (3)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .adc_cmd_trig_out(adc_cmd_trig_out),
    .adc_cmd_addr_out(adc_cmd_addr_out),
    .adc_cmd_data_out(adc_cmd_data_out),
    .dac_cmd_trig_out(dac_cmd_trig_out),
    .dac_cmd_addr_out(dac_cmd_addr_out),
    .dac_cmd_data_out(dac_cmd_data_out),
    .dac_rdata_in    (dac_rdata_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out),
    .err_index_out   (err_index_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    bit          dac;
    logic [15:0] a;
    logic [15:0] v;
  } ev_t;

  ev_t evq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  c0 = 0;
  int  mode = 0;
  bit  rst_prev = 1'b1;
  logic [31:0] adc_prev = '0;
  logic [31:0] dac_prev = '0;

  // DAC model: mode 0 echoes, mode 1 always fails reg 0,
  // mode 2 fails only the first readback of reg 0
  logic [7:0] mem [256];
  int         rd_cnt = 0;
  always @(posedge clk) begin
    if (rst_in) begin
      rd_cnt <= 0;
    end else if (dac_cmd_trig_out) begin
      if (dac_cmd_addr_out[15]) begin
        rd_cnt <= rd_cnt + 1;
        if ((mode == 1 && dac_cmd_addr_out[7:0] == 8'h00) ||
            (mode == 2 && dac_cmd_addr_out[7:0] == 8'h00 &&
             rd_cnt == 0))
          dac_rdata_in <= 16'h00FF;
        else
          dac_rdata_in <= {8'h00, mem[dac_cmd_addr_out[7:0]]};
      end else begin
        mem[dac_cmd_addr_out[7:0]] <= dac_cmd_data_out[7:0];
      end
    end
  end

  // One cycle: bus monitor, one-hot trig, hold of addr/data
  task automatic step();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (adc_cmd_trig_out === 1'b1 || dac_cmd_trig_out === 1'b1) begin
      vectors++;
      if (adc_cmd_trig_out === 1'b1 && dac_cmd_trig_out === 1'b1) begin
        miscompares++;
        $display("FAIL onehot: cyc=%0d both trig high, want one", cyc);
      end
      e.t   = cyc - c0;
      e.dac = dac_cmd_trig_out;
      e.a   = dac_cmd_trig_out ? dac_cmd_addr_out : adc_cmd_addr_out;
      e.v   = dac_cmd_trig_out ? dac_cmd_data_out : adc_cmd_data_out;
      evq.push_back(e);
    end
    if (!rst_in && !rst_prev) begin
      if (adc_cmd_trig_out !== 1'b1 &&
          {adc_cmd_addr_out, adc_cmd_data_out} !== adc_prev) begin
        vectors++;
        miscompares++;
        $display("FAIL adc_hold: cyc=%0d bus=%h without trig, want %h",
                 cyc, {adc_cmd_addr_out, adc_cmd_data_out}, adc_prev);
      end
      if (dac_cmd_trig_out !== 1'b1 &&
          {dac_cmd_addr_out, dac_cmd_data_out} !== dac_prev) begin
        vectors++;
        miscompares++;
        $display("FAIL dac_hold: cyc=%0d bus=%h without trig, want %h",
                 cyc, {dac_cmd_addr_out, dac_cmd_data_out}, dac_prev);
      end
    end
    adc_prev = {adc_cmd_addr_out, adc_cmd_data_out};
    dac_prev = {dac_cmd_addr_out, dac_cmd_data_out};
    rst_prev = rst_in;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    c0 = cyc;
    evq.delete();
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k = 0;
    while (evq.size() < n && k < budget) begin
      step();
      k++;
    end
    if (evq.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ev: got %0d triggers, want %0d", evq.size(), n);
    end
  endtask

  task automatic wait_end(input int budget, output int t_end);
    int k = 0;
    while (done_out !== 1'b1 && error_out !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    t_end = cyc - c0;
    if (done_out !== 1'b1 && error_out !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    vectors++;
    if ({adc_cmd_trig_out, adc_cmd_addr_out, adc_cmd_data_out,
         dac_cmd_trig_out, dac_cmd_addr_out, dac_cmd_data_out,
         busy_out, done_out, error_out, err_index_out} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b err=%b idx=%h trig=%b%b",
               busy_out, done_out, error_out, err_index_out,
               adc_cmd_trig_out, dac_cmd_trig_out);
    end
  endtask

  task automatic test_sequence();
    int          exp_t[6] = '{17, 26, 35, 44, 54, 63};
    bit          exp_d[6] = '{0, 0, 1, 1, 1, 1};
    logic [15:0] exp_a[6] = '{16'h0001, 16'h0003, 16'h0000,
                              16'h8000, 16'h0002, 16'h8002};
    logic [15:0] exp_v[6] = '{16'h0080, 16'h0001, 16'h0020,
                              16'h0000, 16'h0000, 16'h0000};
    int t_end;
    mode = 0;
    do_reset();
    wait_end(200, t_end);
    vectors++;
    if (evq.size() != 6) begin
      miscompares++;
      $display("FAIL seq_count: got %0d, want 6", evq.size());
    end
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      vectors++;
      if (evq[i].t !== exp_t[i] || evq[i].dac !== exp_d[i] ||
          evq[i].a !== exp_a[i] || evq[i].v !== exp_v[i]) begin
        miscompares++;
        $display("FAIL seq_ev%0d: got t=%0d dac=%0b a=%h d=%h, want t=%0d dac=%0b a=%h d=%h",
                 i, evq[i].t, evq[i].dac, evq[i].a, evq[i].v,
                 exp_t[i], exp_d[i], exp_a[i], exp_v[i]);
      end
    end
    vectors++;
    if (t_end !== 72 || done_out !== 1'b1 || busy_out !== 1'b0 ||
        error_out !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_done: got t=%0d done=%b busy=%b err=%b, want 72 1 0 0",
               t_end, done_out, busy_out, error_out);
    end
  endtask

  task automatic test_retry_error();
    int          exp_t[8] = '{17, 26, 35, 44, 53, 62, 71, 80};
    logic [15:0] exp_a[8] = '{16'h0001, 16'h0003, 16'h0000, 16'h8000,
                              16'h0000, 16'h8000, 16'h0000, 16'h8000};
    logic [15:0] exp_v[8] = '{16'h0080, 16'h0001, 16'h0020, 16'h0000,
                              16'h0020, 16'h0000, 16'h0020, 16'h0000};
    int t_end;
    mode = 1;
    do_reset();
    wait_end(300, t_end);
    vectors++;
    if (evq.size() != 8) begin
      miscompares++;
      $display("FAIL rerr_count: got %0d, want 8", evq.size());
    end
    for (int i = 0; i < 8 && i < evq.size(); i++) begin
      vectors++;
      if (evq[i].t !== exp_t[i] || evq[i].dac !== (i >= 2) ||
          evq[i].a !== exp_a[i] || evq[i].v !== exp_v[i]) begin
        miscompares++;
        $display("FAIL rerr_ev%0d: got t=%0d a=%h d=%h, want t=%0d a=%h d=%h",
                 i, evq[i].t, evq[i].a, evq[i].v,
                 exp_t[i], exp_a[i], exp_v[i]);
      end
    end
    vectors++;
    if (t_end !== 88 || error_out !== 1'b1 || err_index_out !== 8'd2 ||
        busy_out !== 1'b0 || done_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rerr_state: got t=%0d err=%b idx=%0d busy=%b done=%b, want 88 1 2 0 0",
               t_end, error_out, err_index_out, busy_out, done_out);
    end
    repeat (30) step();
    vectors++;
    if (evq.size() != 8 || error_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rerr_quiet: got %0d trig err=%b, want 8 1",
               evq.size(), error_out);
    end
  endtask

  task automatic test_retry_once();
    int          exp_t[8] = '{17, 26, 35, 44, 53, 62, 72, 81};
    logic [15:0] exp_a[8] = '{16'h0001, 16'h0003, 16'h0000, 16'h8000,
                              16'h0000, 16'h8000, 16'h0002, 16'h8002};
    logic [15:0] exp_v[8] = '{16'h0080, 16'h0001, 16'h0020, 16'h0000,
                              16'h0020, 16'h0000, 16'h0000, 16'h0000};
    int t_end;
    mode = 2;
    do_reset();
    wait_end(300, t_end);
    vectors++;
    if (evq.size() != 8) begin
      miscompares++;
      $display("FAIL ronce_count: got %0d, want 8", evq.size());
    end
    for (int i = 0; i < 8 && i < evq.size(); i++) begin
      vectors++;
      if (evq[i].t !== exp_t[i] || evq[i].dac !== (i >= 2) ||
          evq[i].a !== exp_a[i] || evq[i].v !== exp_v[i]) begin
        miscompares++;
        $display("FAIL ronce_ev%0d: got t=%0d a=%h d=%h, want t=%0d a=%h d=%h",
                 i, evq[i].t, evq[i].a, evq[i].v,
                 exp_t[i], exp_a[i], exp_v[i]);
      end
    end
    vectors++;
    if (t_end !== 90 || done_out !== 1'b1 || error_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ronce_done: got t=%0d done=%b err=%b, want 90 1 0",
               t_end, done_out, error_out);
    end
  endtask

  task automatic test_reset_midwait();
    mode = 0;
    do_reset();
    wait_ev(2, 100);
    repeat (3) step();
    vectors++;
    if (adc_cmd_addr_out !== 16'h0003) begin
      miscompares++;
      $display("FAIL mid_pre: adc addr=%h, want 0003", adc_cmd_addr_out);
    end
    rst_in = 1'b1;
    step();
    vectors++;
    if ({adc_cmd_trig_out, adc_cmd_addr_out, adc_cmd_data_out,
         dac_cmd_trig_out, dac_cmd_addr_out, dac_cmd_data_out,
         busy_out, done_out} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_rst: adc=%h dac=%h busy=%b, want 0 0 1",
               {adc_cmd_addr_out, adc_cmd_data_out},
               {dac_cmd_addr_out, dac_cmd_data_out}, busy_out);
    end
    rst_in = 1'b0;
    c0 = cyc;
    evq.delete();
    wait_ev(1, 100);
    if (evq.size() > 0) begin
      vectors++;
      if (evq[0].t !== 17 || evq[0].dac !== 1'b0 ||
          evq[0].a !== 16'h0001) begin
        miscompares++;
        $display("FAIL mid_restart: got t=%0d dac=%0b a=%h, want 17 0 0001",
                 evq[0].t, evq[0].dac, evq[0].a);
      end
    end
  endtask

  task automatic test_start();
    int t_end;
    mode = 0;
    do_reset();
    repeat (5) step();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_ev(1, 100);
    repeat (3) step();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_end(200, t_end);
    vectors++;
    if (evq.size() != 6 || evq[0].t !== 17 || evq[1].t !== 26 ||
        done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL start_busy: got n=%0d t0=%0d t1=%0d done=%b, want 6 17 26 1",
               evq.size(), evq[0].t, evq[1].t, done_out);
    end
    evq.delete();
    c0 = cyc;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    vectors++;
    if (busy_out !== 1'b1 || done_out !== 1'b0) begin
      miscompares++;
      $display("FAIL start_clr: busy=%b done=%b, want 1 0",
               busy_out, done_out);
    end
    wait_ev(1, 20);
    if (evq.size() > 0) begin
      vectors++;
      if (evq[0].t !== 2 || evq[0].dac !== 1'b0 ||
          evq[0].a !== 16'h0001 || evq[0].v !== 16'h0080) begin
        miscompares++;
        $display("FAIL start_rerun: got t=%0d a=%h d=%h, want 2 0001 0080",
                 evq[0].t, evq[0].a, evq[0].v);
      end
    end
    wait_end(200, t_end);
    vectors++;
    if (evq.size() != 6 || done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL start_done: got n=%0d done=%b, want 6 1",
               evq.size(), done_out);
    end
    rst_in = 1'b1;
    start_in = 1'b1;
    step();
    rst_in = 1'b0;
    start_in = 1'b0;
    c0 = cyc;
    evq.delete();
    wait_ev(1, 40);
    if (evq.size() > 0) begin
      vectors++;
      if (evq[0].t !== 17) begin
        miscompares++;
        $display("FAIL rst_start: first trig t=%0d, want 17", evq[0].t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_retry_error();
    test_retry_once();
    test_reset_midwait();
    test_start();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
